// File: rtl/fifo_burst_reader.sv
// Read-side FIFO master: drains a programmed burst into a valid/ready stream via a 2-entry skid buffer.
// Optional sticky underflow checker enabled by defining READER_UFLOW_CHK_EN.
module fifo_burst_reader #(
    parameter int FIFO_WIDTH = 16,
    parameter int LEN_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_W-1:0]      burst_len,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_W-1:0]      words_read,
    output logic                  fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  err_underflow
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [LEN_W-1:0]      r_remaining;
    logic [LEN_W-1:0]      r_words_read;
    logic                  r_pend;
    logic [1:0]            r_occ;
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [FIFO_WIDTH-1:0] r_buf [2];
    logic                  w_pop;
    logic                  w_rd_en;
    logic                  w_start_ok;
    logic                  w_busy;
    logic [2:0]            w_fill;

    assign w_start_ok = (r_state == S_IDLE) && start;
    assign w_pop      = (r_occ != 2'd0) && m_ready;
    assign w_busy     = (r_state == S_RUN) || (r_state == S_FLUSH);

    // Issue a read only if the word plus everything in flight still fits after this cycle's pop.
    assign w_fill  = {1'b0, r_occ} + {2'b00, r_pend};
    assign w_rd_en = (r_state == S_RUN) && !fifo_empty && (r_remaining != '0) &&
                     (w_fill < (3'd2 + {2'b00, w_pop}));

    assign fifo_rd_en = w_rd_en;
    assign busy       = w_busy;
    assign done       = (r_state == S_DONE);
    assign words_read = r_words_read;
    assign m_valid    = (r_occ != 2'd0);
    assign m_data     = r_buf[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = (burst_len == '0) ? S_DONE : S_RUN;
            S_RUN:   if (r_remaining == '0) w_state_nxt = S_FLUSH;
            S_FLUSH: if ((r_occ == 2'd0) && !r_pend) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Burst bookkeeping: remaining reads to issue and stream handshakes completed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_remaining  <= '0;
            r_words_read <= '0;
            r_pend       <= 1'b0;
        end else begin
            r_pend <= w_rd_en;
            if (w_start_ok) begin
                r_remaining  <= burst_len;
                r_words_read <= '0;
            end else begin
                if (w_rd_en) r_remaining <= r_remaining - LEN_W'(1);
                if (w_pop) r_words_read <= r_words_read + LEN_W'(1);
            end
        end
    end

    // Skid buffer: tail written the cycle after a read, head popped on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf[0] <= '0;
            r_buf[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (r_pend) begin
                r_buf[r_wr_ptr] <= fifo_data_out;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            case ({r_pend, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

`ifdef READER_UFLOW_CHK_EN
    logic r_err_underflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_underflow <= 1'b0;
        end else if (fifo_underflow && w_busy) begin
            r_err_underflow <= 1'b1;
        end
    end

    assign err_underflow = r_err_underflow;

`ifdef SIM
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(w_rd_en && fifo_empty)) else $error("read issued while FIFO empty");
            assert (r_occ != 2'd3) else $error("skid buffer occupancy above 2");
        end
    end
`endif
`else
    logic w_unused_uflow;

    assign w_unused_uflow = fifo_underflow;
    assign err_underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomized self-checking bench for fifo_burst_reader against a behavioural FIFO and stream model.
module tb_fifo_burst_reader;

    localparam int FW = 16;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] burst_len = '0;
    logic          busy;
    logic          done;
    logic [LW-1:0] words_read;
    logic          fifo_rd_en;
    logic [FW-1:0] fifo_data_out = '0;
    logic          fifo_empty;
    logic          fifo_underflow = 1'b0;
    logic [FW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          err_underflow;

    fifo_burst_reader #(.FIFO_WIDTH(FW), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .burst_len(burst_len),
        .busy(busy), .done(done), .words_read(words_read),
        .fifo_rd_en(fifo_rd_en), .fifo_data_out(fifo_data_out),
        .fifo_empty(fifo_empty), .fifo_underflow(fifo_underflow),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO with a one-cycle registered read port.
    logic [FW-1:0] fmem [0:255];
    int unsigned   wp = 0;
    int unsigned   rp = 0;

    assign fifo_empty = (wp == rp);

    always @(posedge clk) begin
        if (fifo_rd_en && (wp != rp)) begin
            fifo_data_out <= fmem[rp[7:0]];
            rp            <= rp + 1;
        end
    end

    int            checks = 0;
    int            errors = 0;
    logic [FW-1:0] model_q[$];

    // Observations from the most recent burst.
    logic [FW-1:0] pop_data[$];
    int            pop_cyc[$];
    int            rd_cyc[$];
    int            done_cnt, done_cyc, stall_viol, rd_empty, busy_gap, extra_pops, post_bad;
    logic [LW-1:0] wr_at_done;
    bit            timed_out, err_any, err_at_done;

    task automatic fifo_write(input logic [FW-1:0] d);
        fmem[wp[7:0]] = d;
        wp = wp + 1;
        model_q.push_back(d);
    endtask

    task automatic consume(input int n);
        for (int k = 0; k < n; k++) if (model_q.size() > 0) void'(model_q.pop_front());
    endtask

    // mode: 0 ready always high, 1 ready alternating, 2 ready random.
    task automatic run_burst(input int len, input int mode, input int wr_delay, input int n_late,
                             input int uf_cyc);
        logic          prev_stall = 1'b0;
        logic [FW-1:0] prev_data = '0;
        logic          s_valid, s_busy, s_done, s_err;
        logic [FW-1:0] s_data;
        logic [LW-1:0] s_wr;
        pop_data.delete(); pop_cyc.delete(); rd_cyc.delete();
        done_cnt = 0; done_cyc = -1; stall_viol = 0; rd_empty = 0; busy_gap = 0;
        extra_pops = 0; post_bad = 0; wr_at_done = '0; timed_out = 1; err_any = 0; err_at_done = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            s_valid = m_valid; s_data = m_data; s_busy = busy; s_done = done;
            s_wr = words_read; s_err = err_underflow;
            if (cyc == wr_delay) for (int k = 0; k < n_late; k++) fifo_write(FW'($urandom));
            start = (cyc == 0);
            burst_len = LW'(len);
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc % 2 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            fifo_underflow = (cyc == uf_cyc);
            #1;
            if (fifo_rd_en) begin
                rd_cyc.push_back(cyc);
                if (fifo_empty) rd_empty++;
            end
            if (prev_stall && (!s_valid || s_data !== prev_data)) stall_viol++;
            prev_stall = s_valid && !m_ready;
            prev_data = s_data;
            if (s_err) err_any = 1;
            if (s_valid && m_ready) begin
                if (done_cnt > 0) extra_pops++;
                else begin
                    pop_data.push_back(s_data);
                    pop_cyc.push_back(cyc);
                end
            end
            if (s_done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_cyc = cyc; wr_at_done = s_wr; err_at_done = s_err;
                end
            end else if (done_cnt > 0 && (s_busy || s_wr !== wr_at_done)) begin
                post_bad++;
            end
            if (done_cnt == 0 && cyc >= 1 && !s_busy) busy_gap++;
            if (done_cnt > 0 && cyc >= done_cyc + 3) begin
                timed_out = 0;
                break;
            end
        end
        start = 1'b0; m_ready = 1'b0; fifo_underflow = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy, done, words_read, fifo_rd_en, m_valid, m_data, err_underflow} !== '0)
            begin errors++; $display("FAIL reset_outputs: got %h required 0",
                {busy, done, words_read, fifo_rd_en, m_valid, m_data, err_underflow}); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, m_valid} !== 3'b000)
            begin errors++; $display("FAIL idle_after_reset: got %b required 000", {busy, done, m_valid}); end
    endtask

    task automatic test_single_burst();
        for (int i = 1; i <= 8; i++) fifo_write(FW'(i));
        run_burst(8, 0, -1, 0, -1);
        checks++;
        if (timed_out) begin errors++; $display("FAIL single_timeout: got 1 required 0"); end
        checks++;
        if (rd_cyc.size() != 8) begin errors++; $display("FAIL single_rd_count: got %0d required 8", rd_cyc.size()); end
        for (int i = 0; i < rd_cyc.size() && i < 8; i++) begin
            checks++;
            if (rd_cyc[i] != 1 + i) begin errors++; $display("FAIL single_rd_cycle[%0d]: got %0d required %0d", i, rd_cyc[i], 1 + i); end
        end
        checks++;
        if (pop_data.size() != 8) begin errors++; $display("FAIL single_pop_count: got %0d required 8", pop_data.size()); end
        for (int i = 0; i < pop_data.size() && i < 8; i++) begin
            checks++;
            if (pop_cyc[i] != 3 + i) begin errors++; $display("FAIL single_latency[%0d]: got %0d required %0d", i, pop_cyc[i], 3 + i); end
            checks++;
            if (pop_data[i] !== model_q[i]) begin errors++; $display("FAIL single_data[%0d]: got %h required %h", i, pop_data[i], model_q[i]); end
        end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL single_done_pulses: got %0d required 1", done_cnt); end
        checks++;
        if (wr_at_done !== LW'(8)) begin errors++; $display("FAIL single_words_read: got %0d required 8", wr_at_done); end
        checks++;
        if (post_bad + extra_pops != 0) begin errors++; $display("FAIL single_after_done: got %0d required 0", post_bad + extra_pops); end
        consume(8);
    endtask

    task automatic test_stall();
        for (int i = 1; i <= 8; i++) fifo_write(FW'(i));
        run_burst(8, 1, -1, 0, -1);
        checks++;
        if (pop_data.size() != 8) begin errors++; $display("FAIL stall_pop_count: got %0d required 8", pop_data.size()); end
        for (int i = 0; i < pop_data.size() && i < 8; i++) begin
            checks++;
            if (pop_data[i] !== model_q[i]) begin errors++; $display("FAIL stall_data[%0d]: got %h required %h", i, pop_data[i], model_q[i]); end
        end
        checks++;
        if (stall_viol != 0) begin errors++; $display("FAIL stall_hold: got %0d changes required 0", stall_viol); end
        checks++;
        if (done_cnt != 1 || wr_at_done !== LW'(8)) begin errors++; $display("FAIL stall_done: got %0d/%0d required 1/8", done_cnt, wr_at_done); end
        consume(8);
    endtask

    task automatic test_starve();
        for (int i = 0; i < 3; i++) fifo_write(FW'($urandom));
        run_burst(5, 0, 10, 2, -1);
        checks++;
        if (pop_data.size() != 5) begin errors++; $display("FAIL starve_pop_count: got %0d required 5", pop_data.size()); end
        for (int i = 0; i < pop_data.size() && i < 5; i++) begin
            checks++;
            if (pop_data[i] !== model_q[i]) begin errors++; $display("FAIL starve_data[%0d]: got %h required %h", i, pop_data[i], model_q[i]); end
        end
        checks++;
        if (pop_cyc.size() > 3 && pop_cyc[3] < 12) begin errors++; $display("FAIL starve_early_word: got cycle %0d required >=12", pop_cyc[3]); end
        checks++;
        if (busy_gap != 0) begin errors++; $display("FAIL starve_busy: got %0d idle cycles required 0", busy_gap); end
        checks++;
        if (rd_empty != 0) begin errors++; $display("FAIL starve_rd_empty: got %0d required 0", rd_empty); end
        checks++;
        if (done_cnt != 1 || wr_at_done !== LW'(5)) begin errors++; $display("FAIL starve_done: got %0d/%0d required 1/5", done_cnt, wr_at_done); end
        consume(5);
    endtask

    task automatic test_zero_len();
        run_burst(0, 0, -1, 0, -1);
        checks++;
        if (done_cyc != 1) begin errors++; $display("FAIL zero_done_cycle: got %0d required 1", done_cyc); end
        checks++;
        if (rd_cyc.size() != 0) begin errors++; $display("FAIL zero_rd_count: got %0d required 0", rd_cyc.size()); end
        checks++;
        if (wr_at_done !== '0 || done_cnt != 1) begin errors++; $display("FAIL zero_words_read: got %0d/%0d required 0/1", wr_at_done, done_cnt); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int len = $urandom_range(1, 20);
            int pre = $urandom_range(0, len);
            for (int k = 0; k < pre; k++) fifo_write(FW'($urandom));
            run_burst(len, 2, $urandom_range(2, 12), len - pre, -1);
            checks++;
            if (timed_out || pop_data.size() != len) begin errors++; $display("FAIL rand%0d_pop_count: got %0d required %0d", it, pop_data.size(), len); end
            for (int i = 0; i < pop_data.size() && i < len; i++) begin
                checks++;
                if (pop_data[i] !== model_q[i]) begin errors++; $display("FAIL rand%0d_data[%0d]: got %h required %h", it, i, pop_data[i], model_q[i]); end
            end
            checks++;
            if (stall_viol + rd_empty + extra_pops + post_bad != 0) begin errors++; $display("FAIL rand%0d_protocol: got %0d/%0d/%0d/%0d required 0", it, stall_viol, rd_empty, extra_pops, post_bad); end
            checks++;
            if (done_cnt != 1 || wr_at_done !== LW'(len)) begin errors++; $display("FAIL rand%0d_done: got %0d/%0d required 1/%0d", it, done_cnt, wr_at_done, len); end
            consume(len);
        end
    endtask

    task automatic test_midburst_reset();
        int got = 0;
        for (int k = 0; k < 8; k++) fifo_write(FW'($urandom));
        for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
            @(negedge clk);
            start = (cyc == 0); burst_len = LW'(8); m_ready = 1'b1;
            #1;
            if (m_valid) begin
                checks++;
                if (m_data !== model_q[got]) begin errors++; $display("FAIL mid_data[%0d]: got %h required %h", got, m_data, model_q[got]); end
                got++;
            end
        end
        start = 1'b0;
        checks++;
        if (got != 3) begin errors++; $display("FAIL mid_words_before_reset: got %0d required 3", got); end
        @(negedge clk);
        rst = 1'b1;
        m_ready = 1'b0;
        #1;
        checks++;
        if ({busy, done, words_read, fifo_rd_en, m_valid, m_data} !== '0)
            begin errors++; $display("FAIL mid_reset_outputs: got %h required 0", {busy, done, words_read, fifo_rd_en, m_valid, m_data}); end
        @(negedge clk);
        rst = 1'b0;
        wp = rp;
        model_q.delete();
        for (int k = 0; k < 2; k++) fifo_write(FW'($urandom));
        run_burst(2, 0, -1, 0, -1);
        checks++;
        if (pop_data.size() != 2) begin errors++; $display("FAIL mid_restart_count: got %0d required 2", pop_data.size()); end
        for (int i = 0; i < pop_data.size() && i < 2; i++) begin
            checks++;
            if (pop_data[i] !== model_q[i]) begin errors++; $display("FAIL mid_restart_data[%0d]: got %h required %h", i, pop_data[i], model_q[i]); end
        end
        checks++;
        if (done_cnt != 1 || wr_at_done !== LW'(2)) begin errors++; $display("FAIL mid_restart_done: got %0d/%0d required 1/2", done_cnt, wr_at_done); end
        consume(2);
    endtask

    task automatic test_underflow();
        bit exp_err;
`ifdef READER_UFLOW_CHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        run_burst(4, 0, 6, 4, 3);
        checks++;
        if (err_any != exp_err) begin errors++; $display("FAIL uflow_seen: got %0d required %0d", err_any, exp_err); end
        checks++;
        if (err_at_done != exp_err) begin errors++; $display("FAIL uflow_sticky: got %0d required %0d", err_at_done, exp_err); end
        checks++;
        if (pop_data.size() != 4 || done_cnt != 1) begin errors++; $display("FAIL uflow_burst: got %0d/%0d required 4/1", pop_data.size(), done_cnt); end
        consume(4);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (err_underflow !== 1'b0) begin errors++; $display("FAIL uflow_cleared: got %0d required 0", err_underflow); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_stall();
        test_starve();
        test_zero_len();
        test_random();
        test_midburst_reset();
        test_underflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
